// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcode constants and format codes shared by the immediate generator.
package imm_gen_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;
endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// imm_decode: combinational RV32I/RV64I immediate decode, sign-extended to XLEN.
// IMM_GEN_CSR_IMM_EN adds the zero-extended CSR immediate (FMT_Z).
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);
    logic [31:0] word;

    always_comb begin
        word = '0;
        fmt  = FMT_NONE;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                word = {inst[31:12], 12'b0};
                fmt  = FMT_U;
            end
            OP_STORE: begin
                word = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                fmt  = FMT_S;
            end
            OP_BRANCH: begin
                word = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                fmt  = FMT_B;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                word = {{20{inst[31]}}, inst[31:20]};
                fmt  = FMT_I;
            end
            OP_JAL: begin
                word = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                fmt  = FMT_J;
            end
`ifdef IMM_GEN_CSR_IMM_EN
            OP_SYSTEM: begin
                word = {27'b0, inst[19:15]};
                fmt  = inst[14] ? FMT_Z : FMT_NONE;
                word = inst[14] ? word : '0;
            end
`endif
            default: ;
        endcase
        // Every format is already a 32-bit signed value except Z, which must not sign-extend.
        imm = (fmt == FMT_Z) ? XLEN'(word) : XLEN'($signed(word));
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a 2-entry skid buffer.
// Build with IMM_GEN_CSR_IMM_EN to decode csrr*i immediates.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);
    logic [1:0]      count;
    logic [XLEN-1:0] imm_q [2];
    fmt_e            fmt_q [2];
    logic [XLEN-1:0] d_imm;
    fmt_e            d_fmt;
    logic            push, pop;

    imm_decode #(.XLEN(XLEN)) u_dec (.inst(inst), .imm(d_imm), .fmt(d_fmt));

    assign in_ready  = count != 2'(DEPTH);
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign imm       = imm_q[0];
    assign fmt       = fmt_q[0];

    // Slot 0 is always the head; slot 1 only holds the entry that arrived during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            imm_q <= '{default: '0};
            fmt_q <= '{default: FMT_NONE};
        end else begin
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                imm_q[0] <= d_imm;
                fmt_q[0] <= d_fmt;
            end else if (pop && count == 2'd2) begin
                imm_q[0] <= imm_q[1];
                fmt_q[0] <= fmt_q[1];
            end
            if (push && count == 2'd1 && !pop) begin
                imm_q[1] <= d_imm;
                fmt_q[1] <= d_fmt;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe at XLEN=32 and XLEN=64 against a queue model.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    logic        clk = 0;
    logic        rst, in_valid, out_ready;
    logic [31:0] inst;
    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    fmt_e        fmt32, fmt64;
    int          n_cmp = 0, n_bad = 0;
    exp_t        q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .inst(inst),
        .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32), .fmt(fmt32));
    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .inst(inst),
        .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64), .fmt(fmt64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Immediate built from field arithmetic on a sign-extended 64-bit copy of the word.
    function automatic exp_t model(input logic [31:0] i);
        logic signed [63:0] s, sg;
        exp_t e;
        s  = 64'($signed(i));
        sg = s >>> 63;
        e.imm = 64'd0;
        e.fmt = FMT_NONE;
        case (i[6:0])
            7'h37, 7'h17: begin e.imm = s & ~64'hFFF; e.fmt = FMT_U; end
            7'h67, 7'h03, 7'h13: begin e.imm = s >>> 20; e.fmt = FMT_I; end
            7'h23: begin
                e.imm = (sg << 12) | (64'(i[31:25]) << 5) | 64'(i[11:7]);
                e.fmt = FMT_S;
            end
            7'h63: begin
                e.imm = (sg << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
                e.fmt = FMT_B;
            end
            7'h6F: begin
                e.imm = (sg << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
                e.fmt = FMT_J;
            end
`ifdef IMM_GEN_CSR_IMM_EN
            7'h73: if (i[14]) begin e.imm = 64'(i[19:15]); e.fmt = FMT_Z; end
`endif
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) q.delete();
        else begin
            automatic bit do_pop  = q.size() > 0 && out_ready;
            automatic bit do_push = in_valid && q.size() < 2;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model(inst));
        end
    end

    always @(negedge clk) begin
        chk("in_ready32", in_ready32, q.size() < 2);
        chk("in_ready64", in_ready64, q.size() < 2);
        chk("out_valid32", out_valid32, q.size() > 0);
        chk("out_valid64", out_valid64, q.size() > 0);
        if (q.size() > 0) begin
            chk("imm32", imm32, q[0].imm[31:0]);
            chk("imm64", imm64, q[0].imm);
            chk("fmt32", fmt32, q[0].fmt);
            chk("fmt64", fmt64, q[0].fmt);
        end
        if (rst) begin
            chk("rst_imm32", imm32, 0);
            chk("rst_fmt32", fmt32, FMT_NONE);
        end
    end

    task automatic issue(input logic [31:0] w, input logic [63:0] e, input logic [2:0] f);
        in_valid = 1;
        inst = w;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("lit_valid", out_valid32, 1);
        chk("lit_imm32", imm32, e[31:0]);
        chk("lit_imm64", imm64, e);
        chk("lit_fmt", fmt32, f);
    endtask

    logic [31:0] pp_words [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h0010006F};

    initial begin
        rst = 1; in_valid = 0; inst = 0; out_ready = 1;
        @(negedge clk);
        chk("reset_valid", out_valid32, 0);
        chk("reset_ready", in_ready32, 1);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        issue(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, FMT_I);
        issue(32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, FMT_S);
        issue(32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, FMT_B);
        issue(32'h123452B7, 64'h0000000012345000, FMT_U);
        issue(32'h0010006F, 64'h0000000000000800, FMT_J);
        issue(32'h0000007F, 64'h0, FMT_NONE);
`ifdef IMM_GEN_CSR_IMM_EN
        issue(32'h000FD0F3, 64'h1F, FMT_Z);
        issue(32'h01F0D0F3, 64'h01, FMT_Z);
`else
        issue(32'h000FD0F3, 64'h0, FMT_NONE);
        issue(32'h01F0D0F3, 64'h0, FMT_NONE);
`endif
        @(posedge clk);
        #1;

        // Backpressure: three pushes against a stalled consumer.
        out_ready = 0; in_valid = 1; inst = 32'hFFF00093;
        @(posedge clk);
        #1 inst = 32'hFE112E23;
        @(posedge clk);
        #1 inst = 32'h123452B7;
        @(negedge clk);
        chk("bp_full_ready", in_ready32, 0);
        chk("bp_head", imm32, 32'hFFFFFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_hold_ready", in_ready32, 0);
        chk("bp_hold_head", imm32, 32'hFFFFFFFF);
        out_ready = 1;
        @(negedge clk);
        chk("bp_second", imm32, 32'hFFFFFFFC);
        chk("bp_reopen", in_ready32, 1);
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("bp_third", imm32, 32'h12345000);
        @(posedge clk);
        #1;

        // Steady push/pop with one entry resident.
        out_ready = 0; in_valid = 1; inst = pp_words[0];
        @(posedge clk);
        #1 out_ready = 1;
        for (int k = 1; k <= 10; k++) begin
            inst = pp_words[k % 5];
            @(posedge clk);
            #1 chk("pp_ready", in_ready32, 1);
            chk("pp_valid", out_valid32, 1);
        end
        in_valid = 0;
        @(posedge clk);
        #1;

        // Reset while full.
        out_ready = 0; in_valid = 1; inst = 32'hFE000CE3;
        repeat (2) @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        #2 rst = 1;
        @(posedge clk);
        #1 chk("mid_rst_valid", out_valid32, 0);
        chk("mid_rst_ready", in_ready32, 1);
        chk("mid_rst_imm", imm32, 0);
        chk("mid_rst_fmt", fmt32, FMT_NONE);
        rst = 0; out_ready = 1; in_valid = 1; inst = 32'h0010006F;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("post_rst_imm", imm32, 32'h00000800);
        chk("post_rst_fmt", fmt32, FMT_J);
        @(posedge clk);
        #1 chk("post_rst_empty", out_valid32, 0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
